// File: rtl/rv32_pkg.sv
// Shared RV32I load/store encodings and memory-port arbiter state type.
// Also hosts the alignment rule so the grant path and the lane logic agree on it.
package rv32_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DERR  = 2'd3
    } arb_state_e;

    // Unlisted funct3 encodings fall through to word size.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane steering and load extraction for one data access.
// Zero latency; no handshake, pure function of the latched access fields.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_en;

    always_comb begin
        byte_sel     = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel     = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        sign_en      = ~funct3_i[2];
        misaligned_o = is_misaligned(funct3_i, addr_lo_i);
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sign_en & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sign_en & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store; data wins, fetch is starvation-bounded.
// Req-to-done is 2 cycles plus memory wait states; a mem_req holds all mem_* fields stable until mem_ready.
module mem_port_arbiter
    import rv32_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e         state_q;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic [31:0]        addr_q, wdata_q, i_rdata_q, d_rdata_q;
    logic [2:0]         f3_q;
    logic               we_q, mem_req_q, i_done_q, d_done_q, d_err_q;
    logic               data_wins, grant_d, grant_i;
    logic [3:0]         al_be;
    logic [31:0]        al_wdata, al_rdata;
    logic               al_mis;

    lsu_align u_align (
        .funct3_i     (f3_q),
        .addr_lo_i    (addr_q[1:0]),
        .wdata_i      (wdata_q),
        .rdata_i      (mem_rdata),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_mis)
    );

    // A requester whose done is showing sits out one cycle; if data would win
    // that cycle the slot stays empty rather than passing to fetch.
    always_comb begin
        data_wins = d_req && (!i_req || (starve_q < STARVE_LIM));
        grant_d   = (state_q == IDLE) && data_wins && !d_done_q;
        grant_i   = (state_q == IDLE) && !data_wins && i_req && !i_done_q;
        starve_d  = starve_q;
        if (state_q == IDLE) begin
            if (grant_i || !i_req) begin
                starve_d = '0;
            end else if (grant_d && (starve_q != STARVE_LIM)) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
            mem_req_q <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            d_err_q  <= 1'b0;
            starve_q <= starve_d;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        addr_q  <= d_addr;
                        we_q    <= d_we;
                        f3_q    <= d_funct3;
                        wdata_q <= d_wdata;
                        if (is_misaligned(d_funct3, d_addr[1:0])) begin
                            state_q <= DERR;
                        end else begin
                            state_q   <= DBUSY;
                            mem_req_q <= 1'b1;
                        end
                    end else if (grant_i) begin
                        addr_q    <= i_addr;
                        we_q      <= 1'b0;
                        f3_q      <= LW;
                        wdata_q   <= '0;
                        state_q   <= IBUSY;
                        mem_req_q <= 1'b1;
                    end
                end
                IBUSY: begin
                    if (mem_ready) begin
                        i_done_q  <= 1'b1;
                        i_rdata_q <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                DBUSY: begin
                    if (mem_ready) begin
                        d_done_q  <= 1'b1;
                        d_rdata_q <= we_q ? '0 : al_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                DERR: begin
                    d_done_q  <= 1'b1;
                    d_err_q   <= al_mis;
                    d_rdata_q <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Fetch latches LW so the lane logic yields a full-word enable.
    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = mem_req_q ? al_be : 4'b0000;
    assign mem_wdata = mem_req_q ? al_wdata : 32'h0;
    assign i_rdata   = i_rdata_q;
    assign i_done    = i_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-port, variable-latency memory between the instruction-fetch stage and the load/store path of the pipelined RV32I core. Data accesses normally win; a starvation counter guarantees fetch progress. Stores get byte enables and lane replication, and loads get extraction and sign or zero extension, both from funct3. Misaligned data accesses are rejected without touching memory.

## Interface
- `STARVE_MAX`, 4: maximum number of consecutive data grants while `i_req` is pending.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low.
- `i_req` in 1: fetch request; level, may be held high.
- `i_addr` in 32: fetch address; bits [1:0] are ignored.
- `i_rdata` out 32: fetched word; valid while `i_done` is high.
- `i_done` out 1: one-cycle fetch completion pulse.
- `d_req` in 1: data request; level, may be held high.
- `d_we` in 1: 1 = store, 0 = load.
- `d_funct3` in 3: RV32I load/store funct3.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data, taken from the low bytes.
- `d_rdata` out 32: extended load result; valid while `d_done` is high.
- `d_done` out 1: one-cycle data completion pulse.
- `d_err` out 1: misaligned flag; valid while `d_done` is high.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address; bits [1:0] are always 00.
- `mem_wdata` out 32: lane-replicated write data.
- `mem_be` out 4: byte enables.
- `mem_rdata` in 32: memory read word.
- `mem_ready` in 1: memory completes the access in any cycle it is high while `mem_req` is high.

## Operation
- States:
  - IDLE: arbitrates.
  - IBUSY: fetch access in flight.
  - DBUSY: data access in flight.
  - DERR: misaligned data access, no memory traffic.
- Grant rule in IDLE:
  - Data wins if `d_req` is high and either `i_req` is low or `starve_cnt` < `STARVE_MAX`.
  - Otherwise fetch wins if `i_req` is high.
  - A requester whose done pulse is high this cycle is not eligible this cycle (dead cycle), so a held req re-issues only after the requester has updated its address.
- `starve_cnt`:
  - Increments on a data grant made while `i_req` is high; saturates at `STARVE_MAX`.
  - Clears on any fetch grant, and on any IDLE cycle with `i_req` low.
- On grant, latch into registers: address, `d_we`, `d_funct3`, aligned write data, and `mem_be`. Memory outputs are driven only from these registers.
- Misalignment:
  - Halfword with `addr[0]`=1 is misaligned.
  - Word with `addr[1:0]`≠00 is misaligned.
  - A misaligned grant goes to DERR. `mem_req` stays 0.
- Store lanes, by funct3[1:0]:
  - 00: be = 0001 << `addr[1:0]`, data = byte replicated ×4.
  - 01: be = 0011 << (2·`addr[1]`), data = half replicated ×2.
  - 10: be = 1111, data as-is.
- Load extraction, by funct3:
  - 000 lb, 100 lbu: byte at `addr[1:0]`.
  - 001 lh, 101 lhu: half at `addr[1]`.
  - 010 lw: full word.
  - funct3[2]=1 selects zero-extension; otherwise sign-extension.
  - Other funct3 values are treated as lw / sw.
- Fetch accesses always use `mem_we`=0 and `mem_be`=1111.
- `d_rdata` is 0 for stores and errors.

## Timing
- Reset (`reset`=0 at a clock edge) forces: state=IDLE, `starve_cnt`=0, and all outputs 0 (`mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, both done pulses, both rdata, `d_err`).
- Reset mid-access abandons the access; the arbiter ignores any later `mem_ready`. The memory is reset by the same `reset`.
- Normal access:
  - Req sampled in IDLE at edge N → `mem_req`=1 from cycle N+1.
  - `mem_ready` first high in cycle K ≥ N+1 → at edge K+1: done pulse plus registered rdata, `mem_req`=0, state=IDLE.
  - Minimum latency is 2 cycles from req to done.
- `mem_req` and all `mem_*` fields stay stable from the grant until `mem_ready`.
- Misaligned access: DERR lasts 1 cycle; `d_done`=1 and `d_err`=1 two cycles after the request is sampled.
- The other requester may be granted in the same IDLE cycle that the first requester's done is high. Back-to-back throughput is therefore one access per 2+latency cycles.
- Done pulses last exactly one cycle, and only one done is high at a time.

## Structure
- Shared package `rv32_pkg` holds:
  - funct3 load/store encodings: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - arbiter state enum: IDLE, IBUSY, DBUSY, DERR.
- Sub-module `lsu_align` (combinational):
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: be, replicated wdata, extended load data, misaligned flag.
  - Instantiated once, on the latched data fields.
- FSM, `starve_cnt` and the output registers live in `mem_port_arbiter`.

## Test plan
- Reset: drive `reset`=0 mid-DBUSY with `mem_ready`=0 → next cycle all outputs 0 and state IDLE. A later `mem_ready` pulse produces no done pulse.
- Simultaneous `i_req`/`d_req` with zero-wait memory and `STARVE_MAX`=4, both held high:
  - Grant order is D, D, D, D, I, D, …
  - `i_done` appears after the 4th `d_done`.
- Store: sb with `d_addr`=0x1003, `d_wdata`=0xAB → `mem_be`=1000, `mem_wdata`=0xABABABAB, `mem_addr`=0x1000.
- Loads with `mem_rdata`=0x80FF7F01:
  - lb at offset 1 → 0x0000007F.
  - lh at offset 2 → 0xFFFF80FF.
  - lhu at offset 2 → 0x000080FF.
- Misaligned: lw at 0x2002 → `mem_req` stays 0; `d_done`=1 and `d_err`=1 two cycles after the request.
- Wait states: `mem_ready` low for 3 cycles on a fetch of 0x40 → `mem_addr`/`mem_req` stable throughout; `i_done` one cycle after `mem_ready` with `i_rdata`=`mem_rdata`.
